// File: rtl/irig_b_symbol_gen_if.sv
// rtl/irig_b_symbol_gen_if.sv - time fields in, slot symbol/B(DC) level out
interface irig_b_symbol_gen_if;
  logic       en;
  logic [3:0] miao_gewei;
  logic [2:0] miao_shiwei;
  logic [3:0] fen_gewei;
  logic [2:0] fen_shiwei;
  logic [3:0] shi_gewei;
  logic [1:0] shi_shiwei;
  logic [3:0] day_gewei;
  logic [3:0] day_shiwei;
  logic [1:0] day_baiwei;
  logic [3:0] year_gewei;
  logic [3:0] year_shiwei;
  logic [7:0] moni_b_code_out;
  logic       b_dc_out;
  logic       frame_start;
  logic [6:0] slot_idx;

  modport master (
    output en, miao_gewei, miao_shiwei, fen_gewei, fen_shiwei, shi_gewei, shi_shiwei,
           day_gewei, day_shiwei, day_baiwei, year_gewei, year_shiwei,
    input  moni_b_code_out, b_dc_out, frame_start, slot_idx
  );

  modport slave (
    input  en, miao_gewei, miao_shiwei, fen_gewei, fen_shiwei, shi_gewei, shi_shiwei,
           day_gewei, day_shiwei, day_baiwei, year_gewei, year_shiwei,
    output moni_b_code_out, b_dc_out, frame_start, slot_idx
  );
endinterface

// File: rtl/irig_b_symbol_gen.sv
// rtl/irig_b_symbol_gen.sv - IRIG-B frame builder: 100 x 10 ms slots of P/0/1 symbols
module irig_b_symbol_gen #(
  parameter logic [31:0] CNT_1MS_MAX = 32'd124_999,
  parameter logic [7:0]  BCODE_IDLE  = 8'h00,
  parameter logic [7:0]  BCODE_P     = 8'h70,
  parameter logic [7:0]  BCODE_0     = 8'h30,
  parameter logic [7:0]  BCODE_1     = 8'h31
) (
  input logic              pll_c0,
  input logic              rst,
  irig_b_symbol_gen_if.slave bus
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [31:0] ms_cnt_q, ms_cnt_d;
  logic [3:0]  ms_slot_q, ms_slot_d;
  logic [6:0]  slot_q, slot_d;
  logic [37:0] shadow_q, shadow_d;
  logic [7:0]  code_q, code_d;
  logic        dc_q, dc_d;
  logic        fs_q, fs_d;

  logic [37:0] ins;
  logic        ms_wrap, slot_wrap, frame_wrap;
  logic        run_d, is_p, bit_v;
  logic [3:0]  width;
  logic [99:0] frame_bits;

  assign ins = {bus.year_shiwei, bus.year_gewei, bus.day_baiwei, bus.day_shiwei, bus.day_gewei,
                bus.shi_shiwei, bus.shi_gewei, bus.fen_shiwei, bus.fen_gewei,
                bus.miao_shiwei, bus.miao_gewei};

  assign ms_wrap    = (ms_cnt_q == CNT_1MS_MAX);
  assign slot_wrap  = ms_wrap && (ms_slot_q == 4'd9);
  assign frame_wrap = slot_wrap && (slot_q == 7'd99);

  always_comb begin
    state_d   = state_q;
    ms_cnt_d  = 32'd0;
    ms_slot_d = 4'd0;
    slot_d    = 7'd0;
    shadow_d  = shadow_q;
    if (state_q == ST_IDLE) begin
      if (bus.en) begin
        state_d  = ST_RUN;
        shadow_d = ins;
      end
    end else begin
      ms_cnt_d  = ms_wrap ? 32'd0 : ms_cnt_q + 32'd1;
      ms_slot_d = !ms_wrap ? ms_slot_q : ((ms_slot_q == 4'd9) ? 4'd0 : ms_slot_q + 4'd1);
      slot_d    = !slot_wrap ? slot_q : ((slot_q == 7'd99) ? 7'd0 : slot_q + 7'd1);
      if (frame_wrap) begin
        if (bus.en) shadow_d = ins;
        else        state_d  = ST_IDLE;
      end
    end
  end

  // Data bits laid out by slot number, LSB of each field in the lowest slot.
  always_comb begin
    frame_bits        = '0;
    frame_bits[4:1]   = shadow_d[3:0];
    frame_bits[8:6]   = shadow_d[6:4];
    frame_bits[13:10] = shadow_d[10:7];
    frame_bits[17:15] = shadow_d[13:11];
    frame_bits[23:20] = shadow_d[17:14];
    frame_bits[26:25] = shadow_d[19:18];
    frame_bits[33:30] = shadow_d[23:20];
    frame_bits[38:35] = shadow_d[27:24];
    frame_bits[41:40] = shadow_d[29:28];
    frame_bits[53:50] = shadow_d[33:30];
    frame_bits[58:55] = shadow_d[37:34];
  end

  // Outputs are computed from next-state counters so they change with the slot.
  always_comb begin
    run_d = (state_d == ST_RUN);
    is_p  = (slot_d == 7'd0) || ((slot_d % 7'd10) == 7'd9);
    bit_v = frame_bits[slot_d];
    width = is_p ? 4'd8 : (bit_v ? 4'd5 : 4'd2);
    if (!run_d)     code_d = BCODE_IDLE;
    else if (is_p)  code_d = BCODE_P;
    else if (bit_v) code_d = BCODE_1;
    else            code_d = BCODE_0;
    dc_d = run_d && (ms_slot_d < width);
    fs_d = run_d && (slot_d == 7'd0) && (ms_slot_d == 4'd0) && (ms_cnt_d == 32'd0);
  end

  always_ff @(posedge pll_c0) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ms_cnt_q  <= 32'd0;
      ms_slot_q <= 4'd0;
      slot_q    <= 7'd0;
      shadow_q  <= '0;
      code_q    <= BCODE_IDLE;
      dc_q      <= 1'b0;
      fs_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      ms_cnt_q  <= ms_cnt_d;
      ms_slot_q <= ms_slot_d;
      slot_q    <= slot_d;
      shadow_q  <= shadow_d;
      code_q    <= code_d;
      dc_q      <= dc_d;
      fs_q      <= fs_d;
    end
  end

  assign bus.moni_b_code_out = code_q;
  assign bus.b_dc_out        = dc_q;
  assign bus.frame_start     = fs_q;
  assign bus.slot_idx        = slot_q;

endmodule

// File: tb/tb_irig_b_symbol_gen.sv
// tb/tb_irig_b_symbol_gen.sv - directed bench for irig_b_symbol_gen, 100 cycles per slot
module tb_irig_b_symbol_gen;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   passes = 0;
  logic [7:0] exp_code [100];

  irig_b_symbol_gen_if bus ();

  irig_b_symbol_gen #(.CNT_1MS_MAX(32'd9)) dut (
    .pll_c0(clk),
    .rst   (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_code"}, bus.moni_b_code_out, 8'h00);
    chk({tag, "_bdc"},  bus.b_dc_out, 1'b0);
    chk({tag, "_fs"},   bus.frame_start, 1'b0);
    chk({tag, "_slot"}, bus.slot_idx, 7'd0);
  endtask

  task automatic clear_table();
    for (int s = 0; s < 100; s++)
      exp_code[s] = (s == 0 || s % 10 == 9) ? 8'h70 : 8'h30;
  endtask

  task automatic put(input int s, input string bits);
    for (int i = 0; i < bits.len(); i++)
      exp_code[s + i] = (bits[i] == "1") ? 8'h31 : 8'h30;
  endtask

  // Fields for time 23:59:58, day 366, year 24 (seconds unit set separately).
  task automatic table_common();
    clear_table();
    put(6, "101");  put(10, "1001"); put(15, "101");
    put(20, "1100"); put(25, "01");  put(30, "0110"); put(35, "0110");
    put(40, "11");  put(50, "0010"); put(55, "0100");
  endtask

  task automatic do_slot(input int s);
    int   highs = 0;
    int   fs_cnt = 0;
    bit   seen_low = 0;
    bit   gap = 0;
    int   w;
    logic fs0;
    chk($sformatf("slot_idx_%0d", s), bus.slot_idx, s);
    chk($sformatf("code_%0d", s), bus.moni_b_code_out, exp_code[s]);
    fs0 = bus.frame_start;
    for (int i = 0; i < 100; i++) begin
      if (bus.b_dc_out) begin
        highs++;
        if (seen_low) gap = 1;
      end else seen_low = 1;
      if (bus.frame_start) fs_cnt++;
      @(negedge clk);
    end
    w = (exp_code[s] == 8'h70) ? 80 : (exp_code[s] == 8'h31) ? 50 : 20;
    chk($sformatf("width_%0d", s), highs, w);
    chk($sformatf("bdc_contig_%0d", s), gap, 1'b0);
    chk($sformatf("fs_count_%0d", s), fs_cnt, (s == 0) ? 1 : 0);
    if (s == 0) chk("fs_first_cycle", fs0, 1'b1);
  endtask

  task automatic run_slots(input int first, input int last);
    for (int s = first; s <= last; s++) do_slot(s);
  endtask

  initial begin
    bus.en = 1'b0;
    bus.miao_gewei = 4'd0; bus.miao_shiwei = 3'd0;
    bus.fen_gewei = 4'd0;  bus.fen_shiwei = 3'd0;
    bus.shi_gewei = 4'd0;  bus.shi_shiwei = 2'd0;
    bus.day_gewei = 4'd0;  bus.day_shiwei = 4'd0; bus.day_baiwei = 2'd0;
    bus.year_gewei = 4'd0; bus.year_shiwei = 4'd0;

    for (int i = 0; i < 5; i++) begin
      step(1);
      check_reset_outputs($sformatf("reset%0d", i));
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      check_reset_outputs($sformatf("idle%0d", i));
    end

    bus.miao_gewei = 4'd8; bus.miao_shiwei = 3'd5;
    bus.fen_gewei = 4'd9;  bus.fen_shiwei = 3'd5;
    bus.shi_gewei = 4'd3;  bus.shi_shiwei = 2'd2;
    bus.day_gewei = 4'd6;  bus.day_shiwei = 4'd6; bus.day_baiwei = 2'd3;
    bus.year_gewei = 4'd4; bus.year_shiwei = 4'd2;
    bus.en = 1'b1;
    step(1);

    table_common();
    put(1, "0001");
    run_slots(0, 29);
    bus.miao_gewei = 4'd9;
    run_slots(30, 99);

    table_common();
    put(1, "1001");
    run_slots(0, 9);
    bus.year_gewei = 4'd5;
    run_slots(10, 49);
    bus.en = 1'b0;
    run_slots(50, 99);
    check_reset_outputs("stop");
    for (int i = 0; i < 3; i++) begin
      step(1);
      check_reset_outputs($sformatf("stop_idle%0d", i));
    end

    bus.miao_gewei = 4'd2;
    bus.en = 1'b1;
    step(1);
    table_common();
    put(1, "0100");
    run_slots(0, 36);
    chk("pre_rst_slot", bus.slot_idx, 7'd37);
    rst = 1'b1;
    step(1);
    check_reset_outputs("midrst");
    bus.miao_gewei = 4'd7;
    rst = 1'b0;
    step(1);
    put(1, "1110");
    run_slots(0, 9);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
